// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port (CPU / debug) round-robin arbiter for a single-port data memory.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;      // 1 = debug port won the last arbitration
    logic              sel_q, sel_d;        // 1 = debug port owns the current access
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              c_gnt_q, c_gnt_d, d_gnt_q, d_gnt_d;
    logic              c_done_q, c_done_d, d_done_q, d_done_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic              pick_dbg;

    // Debug wins when it asks alone, or on a tie when the CPU was served last.
    assign pick_dbg = d_req & (~c_req | ~last_q);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        c_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        c_done_d    = 1'b0;
        d_done_d    = 1'b0;
        c_rdata_d   = c_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (c_req || d_req) begin
                    state_d     = ACCESS;
                    sel_d       = pick_dbg;
                    last_d      = pick_dbg;
                    mem_we_d    = pick_dbg ? d_we    : c_we;
                    mem_addr_d  = pick_dbg ? d_addr  : c_addr;
                    mem_wdata_d = pick_dbg ? d_wdata : c_wdata;
                    c_gnt_d     = ~pick_dbg;
                    d_gnt_d     = pick_dbg;
                end
            end
            ACCESS: begin
                state_d  = RESP;
                c_done_d = ~sel_q;
                d_done_d = sel_q;
                // mem_rdata reflects mem_addr_q, so it is captured on the way out of ACCESS.
                if (!mem_we_q) begin
                    if (sel_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        c_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            c_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            c_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            c_gnt_q     <= c_gnt_d;
            d_gnt_q     <= d_gnt_d;
            c_done_q    <= c_done_d;
            d_done_q    <= d_done_d;
            c_rdata_q   <= c_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign c_gnt     = c_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign c_done    = c_done_q;
    assign d_done    = d_done_q;
    assign c_rdata   = c_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [7:0] c_addr = 8'h00, d_addr = 8'h00;
    logic [3:0] c_wdata = 4'h0, d_wdata = 4'h0;
    logic       c_gnt, c_done, d_gnt, d_done, mem_we, busy;
    logic [3:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [7:0] mem_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Power-up memory contents: 0x34 -> 5, 0xFF -> F, otherwise low nibble ^ high nibble.
    function automatic logic [3:0] init_val(input logic [7:0] a);
        if (a == 8'h34) return 4'h5;
        if (a == 8'hFF) return 4'hF;
        return a[3:0] ^ a[7:4];
    endfunction

    // Environment memory driven by the DUT.
    bit         env_w [256];
    logic [3:0] env_v [256];
    assign mem_rdata = env_w[mem_addr] ? env_v[mem_addr] : init_val(mem_addr);
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            env_w[mem_addr] <= 1'b1;
            env_v[mem_addr] <= mem_wdata;
        end
    end

    // Transaction model: an accepted request at edge n grants in the cycle after n,
    // completes in the cycle after n+1, and the next request can be taken at n+3.
    int         edge_n = 0, acc_edge = -100, free_at = 0;
    bit         acc_win = 1'b0, acc_we = 1'b0, last_dbg = 1'b1;
    logic [7:0] m_addr = 8'h00;
    logic [3:0] m_wdata = 4'h0;
    logic [3:0] m_rdata [2] = '{4'h0, 4'h0};
    bit         mw_w [256];
    logic [3:0] mw_v [256];

    function automatic logic [3:0] model_rd(input logic [7:0] a);
        return mw_w[a] ? mw_v[a] : init_val(a);
    endfunction

    always @(posedge clk or negedge reset) begin : model
        int n;
        bit win;
        if (!reset) begin
            acc_edge   <= -100;
            free_at    <= 0;
            last_dbg   <= 1'b1;
            m_addr     <= 8'h00;
            m_wdata    <= 4'h0;
            m_rdata[0] <= 4'h0;
            m_rdata[1] <= 4'h0;
        end else begin
            n = edge_n + 1;
            edge_n <= n;
            if (n == acc_edge + 1) begin
                if (acc_we) begin
                    mw_w[m_addr] <= 1'b1;
                    mw_v[m_addr] <= m_wdata;
                end else begin
                    m_rdata[acc_win] <= model_rd(m_addr);
                end
            end
            if (n >= free_at && (c_req || d_req)) begin
                if (c_req && d_req) win = !last_dbg;
                else                win = d_req;
                acc_edge <= n;
                acc_win  <= win;
                acc_we   <= win ? d_we : c_we;
                m_addr   <= win ? d_addr : c_addr;
                m_wdata  <= win ? d_wdata : c_wdata;
                last_dbg <= win;
                free_at  <= n + 3;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit g, dn;
        g  = (edge_n == acc_edge);
        dn = (edge_n == acc_edge + 1);
        chk("m_c_gnt",     c_gnt,     g && !acc_win);
        chk("m_d_gnt",     d_gnt,     g && acc_win);
        chk("m_c_done",    c_done,    dn && !acc_win);
        chk("m_d_done",    d_done,    dn && acc_win);
        chk("m_mem_we",    mem_we,    g && acc_we);
        chk("m_busy",      busy,      g || dn);
        chk("m_mem_addr",  mem_addr,  m_addr);
        chk("m_mem_wdata", mem_wdata, m_wdata);
        chk("m_c_rdata",   c_rdata,   m_rdata[0]);
        chk("m_d_rdata",   d_rdata,   m_rdata[1]);
    end

    // One complete access from an idle arbiter; called at a negedge while IDLE.
    task automatic access(input bit dbg, input bit we, input logic [7:0] a,
                          input logic [3:0] wd, input logic [3:0] exp_rd);
        if (dbg) begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
        else     begin c_req = 1'b1; c_we = we; c_addr = a; c_wdata = wd; end
        @(negedge clk);
        chk("acc_gnt",       dbg ? d_gnt : c_gnt, 1);
        chk("acc_other_gnt", dbg ? c_gnt : d_gnt, 0);
        chk("acc_mem_we",    mem_we, we);
        chk("acc_mem_addr",  mem_addr, a);
        if (we) chk("acc_mem_wdata", mem_wdata, wd);
        if (dbg) d_req = 1'b0; else c_req = 1'b0;
        @(negedge clk);
        chk("resp_done",       dbg ? d_done : c_done, 1);
        chk("resp_other_done", dbg ? c_done : d_done, 0);
        chk("resp_mem_we",     mem_we, 0);
        chk("resp_mem_addr",   mem_addr, a);
        chk("resp_busy",       busy, 1);
        if (!we) chk("resp_rdata", dbg ? d_rdata : c_rdata, exp_rd);
        @(negedge clk);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy",    busy, 0);
        chk("rst_pulses",  {c_gnt, d_gnt, c_done, d_done, mem_we}, 0);
        chk("rst_addr",    mem_addr, 0);
        chk("rst_wdata",   mem_wdata, 0);
        chk("rst_rdata",   {c_rdata, d_rdata}, 0);
        #1 reset = 1'b1;

        // CPU write, then CPU read
        access(1'b0, 1'b1, 8'h12, 4'hA, 4'h0);
        access(1'b0, 1'b0, 8'h34, 4'h0, 4'h5);
        chk("cpu_rd_hold", c_rdata, 4'h5);

        // Tie right after reset: c, d, c, d at 3-cycle spacing
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h01;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("tie_c_gnt", c_gnt, (i % 6 == 0));
            chk("tie_d_gnt", d_gnt, (i % 6 == 3));
        end
        c_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("tie_c_rdata", c_rdata, 4'h1);
        chk("tie_d_rdata", d_rdata, 4'h2);

        // Debug read of the top address; CPU read data must hold
        access(1'b1, 1'b0, 8'hFF, 4'h0, 4'hF);
        chk("dbg_rd_c_keep", c_rdata, 4'h1);

        // Debug request raised only while busy is ignored
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h40; c_wdata = 4'h3;
        @(negedge clk);
        chk("ign_c_gnt", c_gnt, 1);
        c_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h41; d_wdata = 4'h7;
        @(negedge clk);
        chk("ign_c_done", c_done, 1);
        d_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("ign_d_gnt",  d_gnt, 0);
            chk("ign_mem_we", mem_we, 0);
        end
        chk("ign_mem_41", env_w[8'h41], 0);
        chk("wr_mem_40",  env_v[8'h40], 4'h3);

        // Reset during ACCESS of a write aborts it
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h55; c_wdata = 4'h9;
        @(posedge clk); #1;
        chk("pre_rst_we", mem_we, 1);
        #1 reset = 1'b0; c_req = 1'b0;
        #1;
        chk("rst_mid_we",   mem_we, 0);
        chk("rst_mid_gnt",  c_gnt, 0);
        chk("rst_mid_busy", busy, 0);
        @(negedge clk); #1 reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_done", c_done, 0);
            chk("rst_mid_idle", busy, 0);
        end
        chk("rst_mid_mem", env_w[8'h55], 0);

        // First arbitration after reset still works; read back earlier write
        access(1'b0, 1'b0, 8'h12, 4'h0, 4'hA);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 8, address width.
- DATA_W, default 4, data width.
REQ-002 Ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_req  in  1  CPU port request.
- c_we  in  1  CPU port write (1) or read (0).
- c_addr  in  ADDR_W  CPU port address.
- c_wdata  in  DATA_W  CPU port write data.
- c_gnt  out  1  CPU port grant pulse.
- c_done  out  1  CPU port completion pulse.
- c_rdata  out  DATA_W  CPU port read data.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_done, d_rdata: debug/loader port, identical widths and meanings to the CPU port.
- mem_we  out  1  data memory write enable.
- mem_addr  out  ADDR_W  data memory address.
- mem_wdata  out  DATA_W  data memory write data.
- mem_rdata  in  DATA_W  data memory combinational read data for mem_addr.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS and RESP; each non-IDLE state SHALL last exactly one cycle.
REQ-004 Transitions SHALL be:
- IDLE -> ACCESS when c_req or d_req is sampled high.
- IDLE -> IDLE otherwise.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-005 req, we, addr and wdata SHALL be sampled only in IDLE; requests in ACCESS or RESP SHALL be ignored, not queued.
REQ-006 Arbitration with only one req high SHALL grant that port.
REQ-007 Arbitration with both req high SHALL be round-robin: grant the port not granted most recently.
REQ-008 The last-granted pointer SHALL update only on a grant.
REQ-009 On the IDLE -> ACCESS edge, the winner's we, addr and wdata SHALL be registered into mem_we, mem_addr and mem_wdata, and a winner-select register SHALL be set.
REQ-010 In ACCESS:
- mem_we SHALL equal the registered we, high for exactly one cycle on a write.
- The winner's gnt SHALL be high for exactly that cycle; the loser's gnt SHALL stay low.
REQ-011 At the ACCESS -> RESP edge:
- mem_rdata SHALL be captured into the winner's rdata register on a read.
- mem_we SHALL return to 0.
- mem_addr and mem_wdata SHALL hold their values.
REQ-012 In RESP, the winner's done SHALL be high for exactly one cycle, for both reads and writes; x_rdata SHALL be valid when x_done is high.
REQ-013 x_rdata SHALL hold its value until that port's next read completes; writes SHALL NOT modify x_rdata.
REQ-014 A requester SHALL hold req and attributes stable until gnt and SHALL drop req in the cycle after gnt.
REQ-015 A req still high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-016 A req dropped before being sampled in IDLE SHALL produce no gnt and no memory access.
REQ-017 Latency from req sampled in IDLE to done SHALL be 2 cycles (gnt in cycle +1, done in cycle +2).
REQ-018 Throughput SHALL be at most one access per 3 cycles.
REQ-019 A losing requester holding req SHALL be granted in the next arbitration, so its worst-case wait is 3 cycles.
REQ-020 Addresses SHALL pass through unmodified with no range check; all 2^ADDR_W addresses are legal.
REQ-021 busy SHALL be high in ACCESS and RESP and low in IDLE.

Reset
REQ-022 Asserting reset low SHALL, asynchronously and regardless of state, force:
- state to IDLE, and the last-granted pointer to debug, so the CPU wins the first tie.
- mem_we, all gnt, all done and busy to 0.
- mem_addr, mem_wdata, c_rdata and d_rdata to 0.
REQ-023 Reset asserted during ACCESS SHALL drop mem_we immediately; no done SHALL be issued for the aborted access.
REQ-024 After reset deasserts, the first arbitration SHALL occur at the first rising edge with state IDLE.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- CPU write alone: c_req=1, c_we=1, c_addr=0x12, c_wdata=0xA -> next cycle mem_we=1, mem_addr=0x12, mem_wdata=0xA, c_gnt=1; following cycle c_done=1, mem_we=0.
- CPU read alone: memory holds 0x5 at 0x34; c_req=1, c_we=0, c_addr=0x34 -> c_gnt at +1, c_done=1 and c_rdata=0x5 at +2, d_gnt and d_done stay 0.
- Tie after reset: c_req and d_req both held high -> grants alternate c, d, c, d at 3-cycle spacing, with gnt pulses 3 cycles apart.
- Debug read while CPU idle: d_addr=0xFF holding 0xF -> d_rdata=0xF with d_done; c_rdata keeps its prior value.
- Reset mid-ACCESS: reset low in the mem_we=1 cycle -> mem_we, gnt and busy=0 within that cycle; no done pulse; state IDLE after release.
- Request ignored while busy: d_req raised only during ACCESS/RESP of a CPU access and dropped before IDLE -> no d_gnt and no memory access.
